// File: rtl/subleq_mem_arb.sv
// Round-robin arbiter sharing the single-port SUBLEQ memory between the core (port 0)
// and the loader/debug port (port 1); read data returns to the requester one cycle later.
module subleq_mem_arb #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  input  logic          l_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LDR  = 1'b1
  } port_e;

  port_e last_q, last_d;
  port_e rd_port_q, rd_port_d;
  logic  rd_pend_q, rd_pend_d;

  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst) begin
      if (c_req && l_req) begin
        // Lock pins priority to the loader; otherwise the port not served last wins.
        if (l_lock || last_q == PORT_CORE) l_gnt = 1'b1;
        else                               c_gnt = 1'b1;
      end else begin
        c_gnt = c_req;
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    mem_en    = c_gnt | l_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
  end

  always_comb begin
    last_d    = last_q;
    rd_port_d = rd_port_q;
    rd_pend_d = mem_en & ~mem_we;
    if (l_gnt) begin
      last_d    = PORT_LDR;
      rd_port_d = PORT_LDR;
    end else if (c_gnt) begin
      last_d    = PORT_CORE;
      rd_port_d = PORT_CORE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q    <= PORT_LDR;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_CORE;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // A read in flight when reset asserts must not surface during the reset cycle.
  assign c_rvalid = rst & rd_pend_q & (rd_port_q == PORT_CORE);
  assign l_rvalid = rst & rd_pend_q & (rd_port_q == PORT_LDR);
  assign c_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule
